pre_ifu: RTL and testbench

Pre-fetch stage of the in-order pipeline, directly upstream of the IF stage. Owns the fetch PC and issues one-at-a-time instruction requests on the request/acknowledge instruction-bus interface (`req`/`addr_ok`/`data_ok`). Cancels in-flight fetches on branch or flush redirects, buffers the returned word and hands {pc, inst, adef} to IF under a valid/allowin handshake.

---
 rtl/pre_ifu.sv | 153 +++++++++++++++
 tb/tb_pre_ifu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_ifu.sv
// Pre-fetch stage: owns the fetch PC and issues single outstanding requests on the
// req/addr_ok/data_ok instruction bus. `PREIF_BYPASS_EN` enables data_ok -> IF bypass.
module pre_ifu #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        if_allowin,
    output logic        pre_to_if_valid,
    output logic [31:0] pre_to_if_pc,
    output logic [31:0] pre_to_if_inst,
    output logic        pre_to_if_adef
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   buf_pc;
    logic [XLEN-1:0]   buf_inst;
    logic              buf_adef;
    logic              discard;
    logic              redir_vld;
    logic              redir_flush;
    logic [XLEN-1:0]   redir_pc;

    logic              br_eff;
    logic              redir_ev;
    logic              eff_vld;
    logic              eff_flush;
    logic [XLEN-1:0]   eff_pc;
    logic [XLEN-1:0]   seq_pc;
    logic              pc_misaligned;
    logic              bypass;

    // A pending flush shadows any later branch until it is consumed.
    assign br_eff        = br_taken & ~(redir_vld & redir_flush);
    assign redir_ev      = flush | br_eff;
    assign eff_vld       = redir_vld | redir_ev;
    assign eff_pc        = flush ? flush_target : (br_eff ? br_target : redir_pc);
    assign eff_flush     = flush | (redir_flush & ~br_eff);
    assign seq_pc        = fetch_pc + XLEN'(4);
    assign pc_misaligned = (fetch_pc[1:0] != 2'b00);

`ifdef PREIF_BYPASS_EN
    assign bypass = (state == S_WAIT) & inst_sram_data_ok & ~discard & ~redir_ev & if_allowin;
`else
    assign bypass = 1'b0;
`endif

    assign inst_sram_req   = resetn & (state == S_REQ) & ~pc_misaligned;
    assign inst_sram_addr  = resetn ? fetch_pc : '0;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = '0;

    assign pre_to_if_valid = resetn & ((state == S_HOLD) | bypass);
    assign pre_to_if_pc    = bypass ? fetch_pc : buf_pc;
    assign pre_to_if_inst  = bypass ? inst_sram_rdata : buf_inst;
    assign pre_to_if_adef  = bypass ? 1'b0 : buf_adef;

    // Fetch FSM; every entry into REQ consumes the pending redirect.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            buf_pc      <= '0;
            buf_inst    <= '0;
            buf_adef    <= 1'b0;
            discard     <= 1'b0;
            redir_vld   <= 1'b0;
            redir_flush <= 1'b0;
            redir_pc    <= '0;
        end else begin
            redir_vld   <= eff_vld;
            redir_flush <= eff_flush;
            redir_pc    <= eff_pc;
            case (state)
                S_REQ: begin
                    if (pc_misaligned) begin
                        if (redir_ev) begin
                            fetch_pc  <= eff_pc;
                            redir_vld <= 1'b0;
                        end else begin
                            buf_pc   <= fetch_pc;
                            buf_inst <= '0;
                            buf_adef <= 1'b1;
                            state    <= S_HOLD;
                        end
                    end else begin
                        if (redir_ev) begin
                            discard <= 1'b1;
                        end
                        if (inst_sram_addr_ok) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (discard || redir_ev) begin
                            discard   <= 1'b0;
                            state     <= S_REQ;
                            fetch_pc  <= eff_vld ? eff_pc : fetch_pc;
                            redir_vld <= 1'b0;
                        end else if (bypass) begin
                            state    <= S_REQ;
                            fetch_pc <= seq_pc;
                        end else begin
                            buf_pc   <= fetch_pc;
                            buf_inst <= inst_sram_rdata;
                            buf_adef <= 1'b0;
                            state    <= S_HOLD;
                        end
                    end else if (redir_ev) begin
                        discard <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redir_ev || if_allowin) begin
                        state     <= S_REQ;
                        fetch_pc  <= eff_vld ? eff_pc : seq_pc;
                        redir_vld <= 1'b0;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pre_ifu.sv
// Bench for pre_ifu: directed timing scenarios followed by a randomized bus/redirect run,
// with a transaction-level model of the expected fetch stream.
module tb_pre_ifu;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_target = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        if_allowin = 1'b0;
    logic        pre_to_if_valid;
    logic [31:0] pre_to_if_pc;
    logic [31:0] pre_to_if_inst;
    logic        pre_to_if_adef;

    pre_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .flush_target      (flush_target),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .if_allowin        (if_allowin),
        .pre_to_if_valid   (pre_to_if_valid),
        .pre_to_if_pc      (pre_to_if_pc),
        .pre_to_if_inst    (pre_to_if_inst),
        .pre_to_if_adef    (pre_to_if_adef)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Bus model and expected-stream model state
    bit          outstanding = 1'b0;
    logic [31:0] out_addr = '0;
    logic [31:0] exp_pc = RESET_PC;
    bit          flush_out = 1'b0;
    int unsigned n_xfer = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          rand_bus = 1'b0;
    bit          rand_ctl = 1'b0;
    int unsigned aok_hold = 0;
    int unsigned dok_hold = 0;

    logic        s_req, s_valid, s_adef, s_xfer;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check just before the edge, then advance the models.
    task automatic tick();
        if (aok_hold > 0) begin
            inst_sram_addr_ok = 1'b0;
            aok_hold--;
        end else begin
            inst_sram_addr_ok = rand_bus ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
        if (outstanding && dok_hold == 0)
            inst_sram_data_ok = rand_bus ? 1'($urandom_range(0, 1)) : 1'b1;
        else
            inst_sram_data_ok = 1'b0;
        if (outstanding && dok_hold > 0) dok_hold--;
        inst_sram_rdata = inst_sram_data_ok ? mem(out_addr) : $urandom;
        if (rand_ctl) begin
            if_allowin   = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 39) == 0);
            flush_target = 32'h1c000000 + 32'($urandom_range(0, 1023)) * 32'd4
                           + (($urandom_range(0, 5) == 0) ? 32'd2 : 32'd0);
            br_taken     = !flush_out && ($urandom_range(0, 29) == 0);
            br_target    = 32'h1c000000 + 32'($urandom_range(0, 1023)) * 32'd4;
        end
        #1;
        s_req   = inst_sram_req;
        s_addr  = inst_sram_addr;
        s_valid = pre_to_if_valid;
        s_pc    = pre_to_if_pc;
        s_inst  = pre_to_if_inst;
        s_adef  = pre_to_if_adef;
        s_xfer  = s_valid && if_allowin && !flush && !br_taken;
        if (s_req) begin
            check("req_aligned", 32'(s_addr[1:0]), 32'd0);
            check("one_outstanding", 32'(outstanding), 32'd0);
        end
        if (prev_stall) begin
            check("req_held", 32'(s_req), 32'd1);
            check("addr_held", s_addr, prev_addr);
        end
        if (s_xfer) begin
            check("xfer_pc", s_pc, exp_pc);
            check("xfer_adef", 32'(s_adef), 32'(exp_pc[1:0] != 2'b00));
            check("xfer_inst", s_inst, (exp_pc[1:0] != 2'b00) ? 32'd0 : mem(exp_pc));
        end
        @(posedge clk);
        prev_stall = s_req && !inst_sram_addr_ok;
        prev_addr  = s_addr;
        if (inst_sram_data_ok) outstanding = 1'b0;
        if (s_req && inst_sram_addr_ok) begin
            outstanding = 1'b1;
            out_addr    = s_addr;
        end
        if (flush) begin
            exp_pc    = flush_target;
            flush_out = 1'b1;
        end else if (br_taken) begin
            exp_pc = br_target;
        end else if (s_xfer) begin
            exp_pc    = exp_pc + 32'd4;
            flush_out = 1'b0;
            n_xfer++;
        end
        @(negedge clk);
    endtask

    task automatic wait_req(input int max, output bit saw_valid);
        bit found = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            #1;
            if (inst_sram_req) found = 1'b1;
            else begin
                if (pre_to_if_valid) saw_valid = 1'b1;
                tick();
            end
        end
        if (!found) check("wait_req_timeout", 32'(found), 32'd1);
    endtask

    task automatic wait_valid(input int max, output bit saw_req);
        bit found = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            #1;
            if (pre_to_if_valid) found = 1'b1;
            else begin
                if (inst_sram_req) saw_req = 1'b1;
                tick();
            end
        end
        if (!found) check("wait_valid_timeout", 32'(found), 32'd1);
    endtask

    task automatic wait_xfers(input int unsigned target, input int max);
        for (int i = 0; i < max && n_xfer < target; i++) tick();
        check("xfer_count", n_xfer, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          sv, sr;
        logic [31:0] p0, i0;
        if_allowin = 1'b1;

        // Reset
        tick();
        tick();
        #1;
        check("rst_req", 32'(inst_sram_req), 32'd0);
        check("rst_valid", 32'(pre_to_if_valid), 32'd0);
        check("rst_addr", inst_sram_addr, 32'd0);

        // Zero-wait bus: 3-cycle cadence
        resetn = 1'b1;
        #1;
        check("boot_req", 32'(inst_sram_req), 32'd1);
        check("boot_addr", inst_sram_addr, RESET_PC);
        check("bus_size", 32'(inst_sram_size), 32'd2);
        tick();
        #1;
        check("c1_req", 32'(inst_sram_req), 32'd0);
        check("c1_valid", 32'(pre_to_if_valid), 32'd0);
        tick();
        #1;
        check("c2_valid", 32'(pre_to_if_valid), 32'd1);
        check("c2_pc", pre_to_if_pc, RESET_PC);
        tick();
        #1;
        check("c3_req", 32'(inst_sram_req), 32'd1);
        check("c3_addr", inst_sram_addr, RESET_PC + 32'd4);

        // addr_ok stalled three cycles
        aok_hold = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("stall_req", 32'(inst_sram_req), 32'd1);
            check("stall_addr", inst_sram_addr, RESET_PC + 32'd4);
        end
        wait_xfers(2, 20);
        wait_xfers(3, 20);

        // Branch while waiting for data: word dropped
        wait_req(20, sv);
        dok_hold = 2;
        tick();
        br_taken  = 1'b1;
        br_target = 32'h1c000100;
        tick();
        br_taken = 1'b0;
        wait_req(20, sv);
        check("br_no_stale", 32'(sv), 32'd0);
        check("br_addr", inst_sram_addr, 32'h1c000100);

        // Flush and branch together in HOLD: flush wins
        if_allowin = 1'b0;
        wait_valid(20, sr);
        flush        = 1'b1;
        flush_target = 32'h1c008000;
        br_taken     = 1'b1;
        br_target    = 32'h1c000200;
        tick();
        flush      = 1'b0;
        br_taken   = 1'b0;
        if_allowin = 1'b1;
        #1;
        check("flush_drop_valid", 32'(pre_to_if_valid), 32'd0);
        wait_req(20, sv);
        check("flush_addr", inst_sram_addr, 32'h1c008000);

        // IF stalls five cycles in HOLD
        if_allowin = 1'b0;
        wait_valid(20, sr);
        p0 = pre_to_if_pc;
        i0 = pre_to_if_inst;
        check("hold_pc0", p0, 32'h1c008000);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            check("hold_valid", 32'(pre_to_if_valid), 32'd1);
            check("hold_pc", pre_to_if_pc, p0);
            check("hold_inst", pre_to_if_inst, i0);
            check("hold_noreq", 32'(inst_sram_req), 32'd0);
        end
        if_allowin = 1'b1;
        tick();
        #1;
        check("resume_req", 32'(inst_sram_req), 32'd1);
        check("resume_addr", inst_sram_addr, 32'h1c008004);

        // Misaligned flush target: adef word without a bus request
        if_allowin = 1'b0;
        wait_valid(20, sr);
        flush        = 1'b1;
        flush_target = 32'h1c000002;
        tick();
        flush      = 1'b0;
        if_allowin = 1'b1;
        wait_valid(20, sr);
        check("adef_noreq", 32'(sr), 32'd0);
        check("adef_pc", pre_to_if_pc, 32'h1c000002);
        check("adef_flag", 32'(pre_to_if_adef), 32'd1);
        check("adef_inst", pre_to_if_inst, 32'd0);
        tick();
        br_taken  = 1'b1;
        br_target = 32'h1c000400;
        tick();
        br_taken = 1'b0;

        // Randomized bus latency, backpressure and redirects
        rand_bus = 1'b1;
        rand_ctl = 1'b1;
        repeat (4000) tick();
        rand_ctl = 1'b0;
        flush    = 1'b0;
        br_taken = 1'b0;
        check("progress", 32'(n_xfer > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
